// File: rtl/uart_program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader and its byte receiver.
package uart_program_loader_pkg;

    // 25 MHz system clock, 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
    localparam logic [7:0]  DEFAULT_HDR_BYTE     = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_FRAMING  = 2'd1;
    localparam logic [1:0] ERR_LENGTH   = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CKSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_program_loader_rx_byte.sv
// 8N1 byte receiver working on an already-synchronised rx line; samples at bit centres.
module uart_rx_byte
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       ferr
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_prev  <= 1'b1;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            ferr     <= 1'b0;
        end else begin
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end
                // Half a bit into the start bit the line must still be low, else it was a glitch
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        rx_valid <= 1'b1;
                        rx_byte  <= shift;
                        ferr     <= !rx_sync;
                        state    <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a framed program image over UART and writes it word-by-word into instruction memory,
// holding the processor in reset while the load is in progress.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [7:0]  HDR_BYTE     = DEFAULT_HDR_BYTE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              hold_cpu,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned CAPACITY = 1 << ADDR_W;

    logic              rx_meta;
    logic              rx_sync;
    logic              arm_prev;
    logic              arm_rise;
    logic              rx_valid;
    logic              ferr;
    logic [7:0]        rx_byte;
    loader_state_t     state;
    logic [7:0]        len_hi;
    logic [7:0]        cksum;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] last_word;
    logic [23:0]       word_shift;
    logic [1:0]        byte_idx;
    logic [15:0]       len_full;

    assign arm_rise = arm & ~arm_prev;
    assign len_full = {len_hi, rx_byte};

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock   (clock),
        .reset   (reset),
        .rx_sync (rx_sync),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .ferr    (ferr)
    );

    // Framing FSM; a framing error anywhere past the header aborts before any partial word is written
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            arm_prev   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            hold_cpu   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            len_hi     <= '0;
            cksum      <= '0;
            word_cnt   <= '0;
            last_word  <= '0;
            word_shift <= '0;
            byte_idx   <= '0;
        end else begin
            arm_prev <= arm;
            imem_we  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (arm_rise) begin
                        state    <= ST_WAIT_HDR;
                        hold_cpu <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        word_cnt <= '0;
                        cksum    <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_WAIT_HDR: begin
                    if (rx_valid && rx_byte == HDR_BYTE) begin
                        state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        if (ferr) begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_FRAMING;
                            hold_cpu <= 1'b0; busy <= 1'b0;
                        end else begin
                            len_hi <= rx_byte;
                            cksum  <= cksum + rx_byte;
                            state  <= ST_LEN_LO;
                        end
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        if (ferr) begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_FRAMING;
                            hold_cpu <= 1'b0; busy <= 1'b0;
                        end else if (32'(len_full) > CAPACITY) begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_LENGTH;
                            hold_cpu <= 1'b0; busy <= 1'b0;
                        end else begin
                            cksum     <= cksum + rx_byte;
                            last_word <= ADDR_W'(len_full - 16'd1);
                            state     <= (len_full == 16'd0) ? ST_CKSUM : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        if (ferr) begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_FRAMING;
                            hold_cpu <= 1'b0; busy <= 1'b0;
                        end else begin
                            cksum    <= cksum + rx_byte;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {word_shift, rx_byte};
                                imem_addr  <= word_cnt;
                                word_cnt   <= word_cnt + ADDR_W'(1);
                                if (word_cnt == last_word) begin
                                    state <= ST_CKSUM;
                                end
                            end else begin
                                word_shift <= {word_shift[15:0], rx_byte};
                            end
                        end
                    end
                end
                ST_CKSUM: begin
                    if (rx_valid) begin
                        hold_cpu <= 1'b0;
                        busy     <= 1'b0;
                        if (ferr) begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_FRAMING;
                        end else if (rx_byte == cksum) begin
                            state <= ST_DONE; done <= 1'b1;
                        end else begin
                            state <= ST_ERROR; error <= 1'b1; err_code <= ERR_CHECKSUM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench: directed and randomised frames compared against a frame-level reference model.
module tb_uart_program_loader;
    import uart_program_loader_pkg::*;

    localparam int         CPB = 16;
    localparam int         AW  = 10;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          hold_cpu;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;
    int rx_valid_count = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_done;
    logic          exp_error;
    logic [1:0]    exp_code;

    logic [7:0] q[$];

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .HDR_BYTE    (HDR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .hold_cpu  (hold_cpu),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
        if (dut.u_rx.rx_valid) rx_valid_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] get_addr(input int i);
        if (i < got_addr.size()) return 32'(got_addr[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] get_data(input int i);
        if (i < got_data.size()) return got_data[i];
        return 'x;
    endfunction

    function automatic logic [7:0] calc_cksum(input logic [7:0] f[$], input int from);
        logic [7:0] s = 8'd0;
        for (int i = from; i < f.size(); i++) s = s + f[i];
        return s;
    endfunction

    // Frame-level reference: find the header, cut the stream at the first bad stop bit, then decode fields
    task automatic model_frame(input logic [7:0] f[$], input int bad_idx);
        int         hdr_pos = -1;
        int         stop_at;
        int         n_words;
        int         full_words;
        logic [7:0] body[$];
        logic [7:0] sum;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_code  = ERR_NONE;
        for (int i = 0; i < f.size(); i++) begin
            if (f[i] == HDR) begin
                hdr_pos = i;
                break;
            end
        end
        if (hdr_pos < 0) return;
        stop_at = (bad_idx > hdr_pos) ? bad_idx : f.size();
        for (int i = hdr_pos + 1; i < stop_at; i++) body.push_back(f[i]);
        if (body.size() < 2) begin
            if (stop_at < f.size()) begin exp_error = 1'b1; exp_code = ERR_FRAMING; end
            return;
        end
        n_words = int'(body[0]) * 256 + int'(body[1]);
        if (n_words > (1 << AW)) begin
            exp_error = 1'b1;
            exp_code  = ERR_LENGTH;
            return;
        end
        full_words = (body.size() - 2) / 4;
        if (full_words > n_words) full_words = n_words;
        for (int w = 0; w < full_words; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({body[2+4*w], body[3+4*w], body[4+4*w], body[5+4*w]});
        end
        if (body.size() > 2 + 4 * n_words) begin
            sum = 8'd0;
            for (int i = 0; i < 2 + 4 * n_words; i++) sum = sum + body[i];
            if (body[2+4*n_words] == sum) exp_done = 1'b1;
            else begin exp_error = 1'b1; exp_code = ERR_CHECKSUM; end
        end else if (stop_at < f.size()) begin
            exp_error = 1'b1;
            exp_code  = ERR_FRAMING;
        end
    endtask

    task automatic pulse_arm();
        @(negedge clock); arm = 1'b1;
        repeat (2) @(negedge clock);
        arm = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clock); rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (2 + $urandom_range(0, 3)) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [7:0] f[$], input int bad_idx, input bit arm_mid);
        got_addr.delete();
        got_data.delete();
        pulse_arm();
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i != bad_idx);
            if (arm_mid && i == 2) pulse_arm();
        end
        repeat (6) @(negedge clock);
        model_frame(f, bad_idx);
    endtask

    task automatic verify_frame(input string tag);
        checkOutput({tag, "_writes"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), get_addr(i), 32'(exp_addr[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), get_data(i), exp_data[i]);
        end
        checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_error));
        checkOutput({tag, "_code"}, 32'(err_code), 32'(exp_code));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(!(exp_done || exp_error)));
        checkOutput({tag, "_hold"}, 32'(hold_cpu), 32'(!(exp_done || exp_error)));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, "_hold"}, 32'(hold_cpu), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        int         junk;
        int         hdr_pos;
        int         n;
        int         bad;
        int         rv0;
        bit         arm_mid;
        logic [7:0] b;
        logic [7:0] ck;

        reset = 1'b1;
        arm   = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Two-word frame with a correct checksum, with an ignored arm edge mid-frame
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h60, 8'h3F, 8'h00, 8'h01};
        q.push_back(calc_cksum(q, 1));
        applyStimulus(q, -1, 1'b1);
        verify_frame("two_words");
        checkOutput("two_words_w0", get_data(0), 32'h20010005);
        checkOutput("two_words_w1", get_data(1), 32'h603F0001);

        q[q.size()-1] = 8'hE9;
        applyStimulus(q, -1, 1'b0);
        verify_frame("bad_cksum");
        checkOutput("bad_cksum_code", 32'(err_code), 32'(ERR_CHECKSUM));

        q = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00};
        applyStimulus(q, -1, 1'b0);
        verify_frame("zero_len");
        checkOutput("zero_len_done", 32'(done), 32'd1);

        q = '{8'hA5, 8'h04, 8'h01};
        applyStimulus(q, -1, 1'b0);
        verify_frame("too_long");
        checkOutput("too_long_code", 32'(err_code), 32'(ERR_LENGTH));

        q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        applyStimulus(q, 4, 1'b0);
        verify_frame("framing");
        checkOutput("framing_code", 32'(err_code), 32'(ERR_FRAMING));

        rv0 = rx_valid_count;
        @(negedge clock); rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        checkOutput("glitch_rx_valid", 32'(rx_valid_count - rv0), 32'd0);

        // Reset in the middle of a word aborts without writing
        got_addr.delete();
        got_data.delete();
        pulse_arm();
        q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        foreach (q[i]) send_byte(q[i], 1'b1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("mid_reset_writes", 32'(got_addr.size()), 32'd0);
        q = '{8'hA5, 8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        q.push_back(calc_cksum(q, 1));
        applyStimulus(q, -1, 1'b0);
        verify_frame("after_reset");

        for (int f = 0; f < 6; f++) begin
            q.delete();
            junk = $urandom_range(0, 2);
            repeat (junk) begin
                b = 8'($urandom_range(0, 255));
                if (b == HDR) b = 8'h5A;
                q.push_back(b);
            end
            hdr_pos = q.size();
            q.push_back(HDR);
            n = $urandom_range(0, 3);
            q.push_back(8'h00);
            q.push_back(8'(n));
            repeat (4 * n) q.push_back(8'($urandom));
            ck = calc_cksum(q, hdr_pos + 1);
            if ($urandom_range(0, 1) == 1) ck = ck + 8'd1;
            q.push_back(ck);
            bad = -1;
            if ($urandom_range(0, 3) == 0) bad = $urandom_range(hdr_pos + 1, q.size() - 1);
            arm_mid = (bad < 0 || bad > 2) && ($urandom_range(0, 1) == 1);
            applyStimulus(q, bad, arm_mid);
            verify_frame($sformatf("rand%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
